// File: rtl/id_stage_pipe.sv
// id_stage_pipe
//   Instruction-decode pipeline stage for an RV32/RV64 integer core. Reads the
//   register file (with same-cycle writeback bypass), decodes the instruction
//   into control bits and a sign-extended immediate, detects load-use hazards
//   against the load sitting in EX, and registers the result for EX using a
//   valid/ready handshake on both sides.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid / in_ready      fetch offers an instruction / stage accepts it
//   in_instr, in_pc          offered instruction word and its PC
//   flush                    drop the held and the offered instruction
//   wb_we, wb_addr, wb_data  register-file writeback port
//   ex_load, ex_rd           EX holds a load writing ex_rd
//   out_valid / out_ready    decoded instruction valid / EX accepts it
//   out_pc, out_rs1_val, out_rs2_val, out_imm   registered PC, operands, immediate
//   out_rs1, out_rs2, out_rd                    register indices
//   out_regwrite .. out_illegal                 control bits
//   stall_cnt                saturating count of load-use bubble cycles
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             out_memread,
    output logic             out_memwrite,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_Z, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wb_wr;

    // Writes to x0 or to indices beyond the implemented file are ignored.
    assign w_wb_wr = wb_we && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREGS_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_wr) begin
            r_regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    opcode_e         w_opcode;
    imm_fmt_e        w_fmt;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_known;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_rd_used;
    logic            w_rw;
    logic            w_mr;
    logic            w_mw;
    logic            w_br;
    logic            w_jp;
    logic            w_bad_idx;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_opcode = opcode_e'(in_instr[6:0]);
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_rd     = in_instr[11:7];

    always_comb begin
        w_fmt      = IMM_Z;
        w_known    = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        w_rd_used  = 1'b0;
        w_rw       = 1'b0;
        w_mr       = 1'b0;
        w_mw       = 1'b0;
        w_br       = 1'b0;
        w_jp       = 1'b0;
        case (w_opcode)
            OPC_LOAD:   begin w_fmt = IMM_I; w_rw = 1'b1; w_mr = 1'b1; w_rd_used = 1'b1; end
            OPC_STORE:  begin w_fmt = IMM_S; w_mw = 1'b1; w_rs2_used = 1'b1; end
            OPC_OPIMM:  begin w_fmt = IMM_I; w_rw = 1'b1; w_rd_used = 1'b1; end
            OPC_OP:     begin w_rw = 1'b1; w_rd_used = 1'b1; w_rs2_used = 1'b1; end
            OPC_LUI,
            OPC_AUIPC:  begin w_fmt = IMM_U; w_rw = 1'b1; w_rd_used = 1'b1; w_rs1_used = 1'b0; end
            OPC_JAL:    begin w_fmt = IMM_J; w_rw = 1'b1; w_jp = 1'b1; w_rd_used = 1'b1; w_rs1_used = 1'b0; end
            OPC_JALR:   begin w_fmt = IMM_I; w_rw = 1'b1; w_jp = 1'b1; w_rd_used = 1'b1; end
            OPC_BRANCH: begin w_fmt = IMM_B; w_br = 1'b1; w_rs2_used = 1'b1; end
            default:    w_known = 1'b0;
        endcase
    end

    always_comb begin
        case (w_fmt)
            IMM_I:   w_imm = XLEN'($signed(in_instr[31:20]));
            IMM_S:   w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            IMM_B:   w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                            in_instr[11:8], 1'b0}));
            IMM_U:   w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            IMM_J:   w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                            in_instr[30:21], 1'b0}));
            default: w_imm = '0;
        endcase
    end

    // A reduced (RV32E) file makes any referenced index >= 16 illegal.
    assign w_bad_idx = (NREGS < 32) &&
                       ((w_rs1_used && w_rs1[4]) || (w_rs2_used && w_rs2[4]) ||
                        (w_rd_used && w_rd[4]));
    assign w_illegal = !w_known || w_bad_idx;

    // Operand reads: x0 and unimplemented indices read 0; a writeback to the
    // same register in this cycle is forwarded.
    always_comb begin
        w_rs1_val = '0;
        if ((w_rs1 != 5'd0) && ({1'b0, w_rs1} < NREGS_L)) begin
            if (w_wb_wr && (wb_addr == w_rs1)) w_rs1_val = wb_data;
            else                               w_rs1_val = r_regs[w_rs1[AW-1:0]];
        end
    end

    always_comb begin
        w_rs2_val = '0;
        if ((w_rs2 != 5'd0) && ({1'b0, w_rs2} < NREGS_L)) begin
            if (w_wb_wr && (wb_addr == w_rs2)) w_rs2_val = wb_data;
            else                               w_rs2_val = r_regs[w_rs2[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Handshake and hazard
    // ------------------------------------------------------------------
    logic w_hazard;
    logic w_drain;
    logic w_accept;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_val;
    logic [XLEN-1:0]  r_rs2_val;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_branch;
    logic             r_jump;
    logic             r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_hazard = in_valid && ex_load && (ex_rd != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == ex_rd)) || (w_rs2_used && (w_rs2 == ex_rd)));
    // Output register is free this cycle (empty or being taken by EX).
    assign w_drain  = !r_out_valid || out_ready;
    assign in_ready = flush || (!w_hazard && w_drain);
    assign w_accept = in_valid && !flush && !w_hazard && w_drain;

    // Priority: flush, then accept, then drain (bubble, counted if it is a
    // load-use stall); otherwise a stalled output holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_illegal   <= 1'b0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= in_pc;
            r_rs1_val   <= w_rs1_val;
            r_rs2_val   <= w_rs2_val;
            r_imm       <= w_imm;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_regwrite  <= w_rw && !w_illegal;
            r_memread   <= w_mr && !w_illegal;
            r_memwrite  <= w_mw && !w_illegal;
            r_branch    <= w_br && !w_illegal;
            r_jump      <= w_jp && !w_illegal;
            r_illegal   <= w_illegal;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
            if (w_hazard && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_pc       = r_pc;
    assign out_rs1_val  = r_rs1_val;
    assign out_rs2_val  = r_rs2_val;
    assign out_imm      = r_imm;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_rd       = r_rd;
    assign out_regwrite = r_regwrite;
    assign out_memread  = r_memread;
    assign out_memwrite = r_memwrite;
    assign out_branch   = r_branch;
    assign out_jump     = r_jump;
    assign out_illegal  = r_illegal;
    assign stall_cnt    = r_stall_cnt;

endmodule
